if_fetch_ctrl: RTL and testbench

Instruction-fetch controller between the PC register and the instruction memory. It turns the current PC into a single-outstanding request on the imem interface, captures the returned word into the IF/ID pipeline register, and drives the PC `stall` input so the PC advances exactly once per delivered instruction. It also handles downstream ID stalls (one-word hold buffer) and branch/jump flushes (squash and drain of an in-flight response).

---
 rtl/if_fetch_ctrl_pkg.sv | 17 +
 rtl/if_fetch_ctrl_if.sv | 21 ++
 rtl/if_fetch_ctrl_if_id_reg.sv | 40 ++++
 rtl/if_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-path definitions: imem widths, NOP encoding and fetch FSM state encoding.
package if_fetch_pkg;

    localparam int IMEM_ADDR_W = 32;
    localparam int IMEM_DATA_W = 32;

    localparam logic [IMEM_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus; the fetch controller is master, imem is slave.
interface if_fetch_ctrl_if #(
    parameter int ADDR_W = if_fetch_pkg::IMEM_ADDR_W,
    parameter int DATA_W = if_fetch_pkg::IMEM_DATA_W
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: flush clears, load captures, stall holds, else bubble.
// Latency: one cycle from load to output.
// Backpressure: hold keeps all fields; flush overrides hold.
module if_id_reg #(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 32,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              hold,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_instr <= NOP;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else if (flush) begin
            if_instr <= NOP;
            if_valid <= 1'b0;
        end else if (load) begin
            if_instr <= load_instr;
            if_pc    <= load_pc;
            if_valid <= 1'b1;
        end else if (!hold) begin
            // if_pc is kept so the last delivered PC stays visible on a bubble
            if_instr <= NOP;
            if_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: single-outstanding imem requests, one-word hold buffer, flush drain.
// Latency: word on if_instr the cycle after rvalid; best case 2 cycles per instruction.
// Backpressure: id_stall parks a returned word in the hold buffer; PC stalls until delivery.
module if_fetch_ctrl
    import if_fetch_pkg::*;
#(
    parameter int                DATA_W = IMEM_DATA_W,
    parameter int                ADDR_W = IMEM_ADDR_W,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_INSTR)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_in,
    output logic                pc_stall,
    input  logic                id_stall,
    input  logic                flush,
    if_fetch_ctrl_if.master     imem,
    output logic [DATA_W-1:0]   if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    output logic                if_valid
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [DATA_W-1:0] hold_instr_q;
    logic [ADDR_W-1:0] hold_pc_q;
    logic              deliver;
    logic              hold_load;
    logic [DATA_W-1:0] load_instr;
    logic [ADDR_W-1:0] load_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC is stalled while waiting, so pc_in is still the PC of the returned word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else if (hold_load) begin
            hold_instr_q <= imem.imem_rdata;
            hold_pc_q    <= pc_in;
        end
    end

    always_comb begin
        state_d        = state_q;
        deliver        = 1'b0;
        hold_load      = 1'b0;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_in;
        load_instr     = imem.imem_rdata;
        load_pc        = pc_in;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                imem.imem_req = 1'b1;
                if (imem.imem_gnt) begin
                    state_d = flush ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (flush) begin
                        state_d = ST_REQ;
                    end else if (id_stall) begin
                        hold_load = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = ST_REQ;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                load_instr = hold_instr_q;
                load_pc    = hold_pc_q;
                if (flush) begin
                    state_d = ST_REQ;
                end else if (!id_stall) begin
                    deliver = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // the squashed response must still be consumed before a new request
                if (imem.imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pc_stall = !(deliver || flush);

    if_id_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NOP    (NOP)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (deliver),
        .hold       (id_stall),
        .load_instr (load_instr),
        .load_pc    (load_pc),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: PC register and imem behaviour modelled here, IF/ID checked
// against a transaction-level model of outstanding and buffered words.
module tb_if_fetch_ctrl;
    import if_fetch_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_in;
    logic          pc_stall;
    logic          id_stall;
    logic          flush;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          if_valid;

    always #5 clk = ~clk;

    if_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) imem ();

    if_fetch_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NOP(NOP_INSTR)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_in    (pc_in),
        .pc_stall (pc_stall),
        .id_stall (id_stall),
        .flush    (flush),
        .imem     (imem),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .if_valid (if_valid)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // environment + reference state
    logic [31:0] pc_reg;
    logic [31:0] mem_ovr [logic [31:0]];
    bit          first;
    bit          out_v;
    bit          out_sq;
    logic [31:0] out_addr;
    int          mem_cnt;
    int          rd_lat;
    bit          rand_lat;
    bit          held_v;
    logic [31:0] held_addr;
    logic [31:0] held_data;
    logic        exp_v;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        obs_req;
    logic        obs_stall;
    logic [31:0] obs_addr;
    int          adv_cnt;
    logic [31:0] dlv_q [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
    endfunction

    task automatic model_reset();
        first     = 1'b1;
        out_v     = 1'b0;
        out_sq    = 1'b0;
        mem_cnt   = 0;
        held_v    = 1'b0;
        exp_v     = 1'b0;
        exp_instr = NOP_INSTR;
        exp_pc    = '0;
        pc_reg    = '0;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, check IF/ID after posedge
    task automatic cycle(input logic st, input logic fl, input logic g, input logic [31:0] tgt);
        logic        rv;
        logic [31:0] rd;
        logic        ex_req;
        logic        avail;
        logic        dlv;
        logic [31:0] w_addr;
        logic [31:0] w_data;

        @(negedge clk);
        rv = out_v && (mem_cnt == 0);
        rd = rv ? mem_word(out_addr) : $urandom;
        id_stall         = st;
        flush            = fl;
        imem.imem_gnt    = g;
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rd;
        pc_in            = pc_reg;
        #1;

        ex_req    = !first && !out_v && !held_v;
        obs_req   = imem.imem_req;
        obs_addr  = imem.imem_addr;
        obs_stall = pc_stall;
        check_eq("imem_req", imem.imem_req, ex_req);
        if (ex_req) check_eq("imem_addr", imem.imem_addr, pc_in);

        avail  = 1'b0;
        w_addr = '0;
        w_data = '0;
        if (held_v && !fl) begin
            avail = 1'b1; w_addr = held_addr; w_data = held_data;
        end else if (out_v && rv && !out_sq && !fl) begin
            avail = 1'b1; w_addr = out_addr; w_data = rd;
        end
        dlv = avail && !st;
        check_eq("pc_stall", pc_stall, !(dlv || fl));
        if (!pc_stall) adv_cnt++;

        if (fl) begin
            exp_v = 1'b0; exp_instr = NOP_INSTR;
        end else if (dlv) begin
            exp_v = 1'b1; exp_instr = w_data; exp_pc = w_addr;
        end else if (!st) begin
            exp_v = 1'b0; exp_instr = NOP_INSTR;
        end

        if (ex_req && g) begin
            out_v    = 1'b1;
            out_addr = pc_in;
            out_sq   = fl;
            mem_cnt  = (rand_lat ? int'($urandom_range(1, 3)) : rd_lat) - 1;
        end else if (out_v) begin
            if (rv) begin
                out_v = 1'b0;
                if (avail && st) begin
                    held_v = 1'b1; held_addr = w_addr; held_data = w_data;
                end
            end else begin
                mem_cnt--;
                if (fl) out_sq = 1'b1;
            end
        end else if (held_v && (fl || !st)) begin
            held_v = 1'b0;
        end
        first = 1'b0;

        if (fl) pc_reg = tgt;
        else if (!pc_stall) pc_reg = pc_reg + 32'd4;

        @(posedge clk);
        #1;
        check_eq("if_valid", if_valid, exp_v);
        check_eq("if_instr", if_instr, exp_instr);
        check_eq("if_pc", if_pc, exp_pc);
        if (if_valid) dlv_q.push_back(if_pc);
    endtask

    // Asynchronous reset pulse; outputs must settle with no clock edge in between
    task automatic do_reset();
        #1;
        rst              = 1'b0;
        id_stall         = 1'b0;
        flush            = 1'b0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        #1;
        check_eq("rst_if_valid", if_valid, 1'b0);
        check_eq("rst_if_instr", if_instr, NOP_INSTR);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_imem_req", imem.imem_req, 1'b0);
        check_eq("rst_pc_stall", pc_stall, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] vhist;
        logic [2:0] vh2;

        rst              = 1'b1;
        id_stall         = 1'b0;
        flush            = 1'b0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        pc_in            = '0;
        rand_lat         = 1'b0;
        rd_lat           = 1;
        adv_cnt          = 0;
        mem_ovr[32'h10]  = 32'h2402_0001;
        mem_ovr[32'h14]  = 32'hDEAD_BEEF;
        model_reset();
        do_reset();

        // free run: PCs 0,4,8,C delivered on alternate cycles
        adv_cnt = 0;
        dlv_q.delete();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            vhist[i] = if_valid;
        end
        check_eq("run_valid_pattern", vhist, 9'b1_0101_0100);
        check_eq("run_pc_advances", adv_cnt, 4);
        check_eq("run_words", dlv_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq("run_pc_seq", (i < dlv_q.size()) ? dlv_q[i] : 32'hFFFF_FFFF, 32'(i * 4));

        // id_stall over the response of PC 0x10
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("stall_req_addr", obs_addr, 32'h10);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 32'h0);
            check_eq("stall_pc_held", obs_stall, 1'b1);
            check_eq("stall_no_req", obs_req, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("hold_release_stall", obs_stall, 1'b0);
        check_eq("hold_word_valid", if_valid, 1'b1);
        check_eq("hold_word_instr", if_instr, 32'h2402_0001);
        check_eq("hold_word_pc", if_pc, 32'h10);

        // flush in WAIT, response two cycles later is drained
        rd_lat = 3;
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("drain_req_addr", obs_addr, 32'h14);
        cycle(1'b0, 1'b1, 1'b1, 32'h100);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            check_eq("drain_no_valid", if_valid, 1'b0);
        end
        rd_lat = 1;
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("redirect_req", obs_req, 1'b1);
        check_eq("redirect_addr", obs_addr, 32'h100);

        // flush coincident with rvalid
        cycle(1'b0, 1'b1, 1'b1, 32'h200);
        check_eq("flush_rv_stall", obs_stall, 1'b0);
        check_eq("flush_rv_valid", if_valid, 1'b0);

        // grant withheld 5 cycles, flush to 0x300 part way
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("nognt_req", obs_req, 1'b1);
        check_eq("nognt_addr", obs_addr, 32'h200);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, (i == 1), 1'b0, 32'h300);
            check_eq("nognt_req", obs_req, 1'b1);
            check_eq("nognt_addr", obs_addr, (i >= 2) ? 32'h300 : 32'h200);
            check_eq("nognt_pc_stall", obs_stall, (i != 1));
        end
        rd_lat = 2;
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("gnt_addr", obs_addr, 32'h300);

        // reset while waiting for the response, then resume from IDLE
        do_reset();
        rd_lat = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            vh2[i] = if_valid;
        end
        check_eq("resume_valid_pattern", vh2, 3'b100);
        check_eq("resume_pc", if_pc, 32'h0);

        // randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) < 7, 32'($urandom_range(0, 1023)) << 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
